xbar_txn_monitor: RTL and testbench
===================================

Name: xbar_txn_monitor

Overview:
Parametrised crossbar transaction monitor on the TileLink A/D channels. It captures every A-channel fire, together with the decoded chip select, chip address and a timestamp, into a readable trace FIFO. It also tracks outstanding requests per source and flags protocol errors and timeouts. It sits beside the crossbar datapath, is purely observational and never drives bus signals.

Parameters:
SRC_W, 4, a_source/d_source width; 2**SRC_W sources tracked
CHIP_W, 6, chip_sel width
ADDR_W, 64, a_address/chip_addr width
TRACE_DEPTH, 16, trace FIFO entries (power of two, >=2)
TS_W, 16, free-running timestamp width
TIMEOUT, 1024, cycles an outstanding request may live before timeout (>=2)
CNT_W, 32, event counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
a_opcode  in  3  A opcode
a_source  in  SRC_W  A source id
a_address  in  ADDR_W  A address (used only by the verbose print)
a_valid  in  1  A valid
a_ready  in  1  A ready
chip_sel  in  CHIP_W  decoded target, valid with A
chip_addr  in  ADDR_W  decoded target-local address
d_source  in  SRC_W  D source id
d_valid  in  1  D valid
d_ready  in  1  D ready
clr  in  1  synchronous clear of trace, counters and sticky errors
trc_rd_en  in  1  pop trace head
trc_rd_data  out  3+SRC_W+CHIP_W+ADDR_W+TS_W  head entry {ts, opcode, source, chip_sel, chip_addr}
trc_empty  out  1  trace empty
trc_count  out  $clog2(TRACE_DEPTH)+1  occupancy
trc_overflow  out  1  sticky: entry dropped
a_cnt  out  CNT_W  A fires since clear
d_cnt  out  CNT_W  D fires since clear
outstanding  out  2**SRC_W  per-source outstanding bitmap
err_dup  out  1  sticky: A fired on an already-outstanding source
err_orphan  out  1  sticky: D fired on a non-outstanding source
err_timeout  out  1  sticky: outstanding age reached TIMEOUT
err_src  out  SRC_W  source of the first error since clear

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low. The reset value of every register and output is 0, and trc_empty resets to 1.
- Fire definitions: a_fire = a_valid & a_ready; d_fire = d_valid & d_ready. Only fires are observed.
- Timestamp: TS_W-bit free-running counter that wraps modulo 2**TS_W and is not cleared by clr. An entry carries the timestamp value of its fire cycle.
- Trace push on a_fire; the entry is visible on the next cycle (trc_empty falls, trc_count increments).
- trc_rd_data is show-ahead: the head entry is presented combinationally from storage. Its value is don't-care when empty.
- Pop on trc_rd_en & ~trc_empty. trc_rd_en while empty is ignored.
- When full with a push and no pop, the new entry is dropped, trc_overflow is set, and existing entries are preserved.
- When full with a simultaneous push and pop, both happen, trc_count is unchanged and there is no overflow.
- Read and write pointers wrap modulo TRACE_DEPTH.
- a_cnt/d_cnt increment on the respective fire and wrap at 2**CNT_W.
- Outstanding bit: set on a_fire[a_source] and cleared on d_fire[d_source].
- Same source, same cycle, with A and D both firing and the bit set: the bit stays 1, its age restarts at 0, and no error is raised.
- a_fire on a source whose bit is set, with no matching d_fire that cycle, sets err_dup.
- d_fire on a source whose bit is clear, with no matching a_fire that cycle, sets err_orphan.
- Age counters: one per source, $clog2(TIMEOUT)+1 bits. A counter is 0 while its source is idle, resets to 0 on a_fire, and increments each cycle while outstanding, saturating at TIMEOUT. Reaching TIMEOUT sets err_timeout. The outstanding bit remains set until a D fire arrives.
- Error priority in one cycle: dup > orphan > timeout. Among timeouts, the lowest index wins. err_src latches only when no error flag is already set.
- clr (synchronous, one cycle) empties the FIFO and zeroes counters, overflow, error flags and err_src. It does not touch outstanding, ages or the timestamp. A fire in the same cycle as clr is discarded.
- Reset mid-operation discards all state immediately.
- Simulation only: when the VERBOSE environment check (CHECK_ENV macro) is true, print time, a_address, chip_sel and chip_addr on each a_fire. Error set events are also printed. This code is excluded from synthesis.

Decomposition:
- Package xbar_mon_pkg: parametrised trace-entry struct and the field-order constants.
- Sub-module xbar_mon_trace_fifo: generic show-ahead FIFO with push, pop, full, empty, count and drop-on-full.

Test Plan:
- Reset, then 3 A fires (src 1,2,3; chip_sel 5; chip_addr 0x100, 0x108, 0x110) with a_ready=1 -> trc_count=3, a_cnt=3, outstanding=0x000E. Popping returns entries in order with consecutive timestamps.
- 17 A fires with TRACE_DEPTH=16 and no pops -> trc_count=16 and trc_overflow=1. The head entry is the first fire and the 17th is absent. On a full FIFO, a push and pop in the same cycle give count 16 and no new overflow.
- A fire src 4, then D fire src 4 -> outstanding[4] toggles 1 then 0 with no errors. A second D on src 4 -> err_orphan=1, err_src=4.
- A src 7, then A src 7 again, alongside a D src 7 in the same cycle -> no error. A third A on src 7 with no D -> err_dup=1, err_src=7.
- A src 2 with TIMEOUT=8, no D -> err_timeout set exactly 8 cycles after the fire, err_src=2, outstanding[2] stays 1. Then clr -> errors, counters and trace cleared, but outstanding[2] is still 1.
- Assert rst_n low while the FIFO holds 5 entries and src 9 is outstanding -> all outputs 0 and trc_empty=1 asynchronously.

Source files
------------

// File: rtl/xbar_mon_pkg.sv
// Shared definitions for the crossbar transaction monitor: trace-entry layout
// (fields packed LSB-first as chip_addr, chip_sel, source, opcode, ts).
package xbar_mon_pkg;

  localparam int OPC_W = 3;

  localparam int DEF_SRC_W  = 4;
  localparam int DEF_CHIP_W = 6;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_TS_W   = 16;

  typedef enum logic [2:0] {
    FLD_CHIP_ADDR = 3'd0,
    FLD_CHIP_SEL  = 3'd1,
    FLD_SOURCE    = 3'd2,
    FLD_OPCODE    = 3'd3,
    FLD_TS        = 3'd4
  } trc_field_e;

  // Entry layout at the default widths; wider/narrower builds use the helpers.
  typedef struct packed {
    logic [DEF_TS_W-1:0]   ts;
    logic [OPC_W-1:0]      opcode;
    logic [DEF_SRC_W-1:0]  source;
    logic [DEF_CHIP_W-1:0] chip_sel;
    logic [DEF_ADDR_W-1:0] chip_addr;
  } trc_entry_t;

  function automatic int trc_entry_w(input int src_w, input int chip_w,
                                     input int addr_w, input int ts_w);
    return ts_w + OPC_W + src_w + chip_w + addr_w;
  endfunction

  function automatic int trc_field_lsb(input trc_field_e fld, input int src_w,
                                       input int chip_w, input int addr_w);
    int lsb;
    case (fld)
      FLD_CHIP_ADDR: lsb = 0;
      FLD_CHIP_SEL:  lsb = addr_w;
      FLD_SOURCE:    lsb = addr_w + chip_w;
      FLD_OPCODE:    lsb = addr_w + chip_w + src_w;
      default:       lsb = addr_w + chip_w + src_w + OPC_W;
    endcase
    return lsb;
  endfunction

endpackage

// File: rtl/xbar_mon_trace_fifo.sv
// Show-ahead FIFO: head is read straight from storage, pushes on a full FIFO
// without a pop are dropped and flagged in a sticky overflow bit.
module xbar_mon_trace_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a full FIFO still accepts push+pop.
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
      count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      overflow_d = overflow_q | (push & full & ~do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    logic [WIDTH-1:0] mem_d;

    always_comb begin
      mem_d = mem_q[gi];
      if (do_push && (wr_ptr_q == PTR_W'(gi))) mem_d = push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q[gi] <= '0;
      else        mem_q[gi] <= mem_d;
    end
  end

endmodule

// File: rtl/xbar_txn_monitor.sv
// Passive TileLink A/D monitor: traces A fires, counts fires, tracks per-source
// outstanding requests and flags dup/orphan/timeout protocol errors.
module xbar_txn_monitor
  import xbar_mon_pkg::*;
#(
  parameter  int SRC_W       = 4,
  parameter  int CHIP_W      = 6,
  parameter  int ADDR_W      = 64,
  parameter  int TRACE_DEPTH = 16,
  parameter  int TS_W        = 16,
  parameter  int TIMEOUT     = 1024,
  parameter  int CNT_W       = 32,
  localparam int ENTRY_W     = trc_entry_w(SRC_W, CHIP_W, ADDR_W, TS_W),
  localparam int TCNT_W      = $clog2(TRACE_DEPTH) + 1,
  localparam int NSRC        = 2 ** SRC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         a_opcode,
  input  logic [SRC_W-1:0]   a_source,
  input  logic [ADDR_W-1:0]  a_address,
  input  logic               a_valid,
  input  logic               a_ready,
  input  logic [CHIP_W-1:0]  chip_sel,
  input  logic [ADDR_W-1:0]  chip_addr,
  input  logic [SRC_W-1:0]   d_source,
  input  logic               d_valid,
  input  logic               d_ready,
  input  logic               clr,
  input  logic               trc_rd_en,
  output logic [ENTRY_W-1:0] trc_rd_data,
  output logic               trc_empty,
  output logic [TCNT_W-1:0]  trc_count,
  output logic               trc_overflow,
  output logic [CNT_W-1:0]   a_cnt,
  output logic [CNT_W-1:0]   d_cnt,
  output logic [NSRC-1:0]    outstanding,
  output logic               err_dup,
  output logic               err_orphan,
  output logic               err_timeout,
  output logic [SRC_W-1:0]   err_src
);

  localparam int AGE_W  = $clog2(TIMEOUT) + 1;
  localparam int CA_LSB = trc_field_lsb(FLD_CHIP_ADDR, SRC_W, CHIP_W, ADDR_W);
  localparam int CS_LSB = trc_field_lsb(FLD_CHIP_SEL, SRC_W, CHIP_W, ADDR_W);
  localparam int SR_LSB = trc_field_lsb(FLD_SOURCE, SRC_W, CHIP_W, ADDR_W);
  localparam int OP_LSB = trc_field_lsb(FLD_OPCODE, SRC_W, CHIP_W, ADDR_W);
  localparam int TS_LSB = trc_field_lsb(FLD_TS, SRC_W, CHIP_W, ADDR_W);

  logic [TS_W-1:0]    ts_q, ts_d;
  logic [CNT_W-1:0]   a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
  logic               err_dup_q, err_dup_d, err_orphan_q, err_orphan_d;
  logic               err_timeout_q, err_timeout_d;
  logic [SRC_W-1:0]   err_src_q, err_src_d;
  logic [NSRC-1:0]    busy_bits, tmo_evt;
  logic [ENTRY_W-1:0] trc_entry;
  logic               a_obs, d_obs, same_src, dup_evt, orphan_evt;
  logic [SRC_W-1:0]   tmo_src;
  logic               unused_addr;

  // Fires coinciding with clr are discarded everywhere, not just in the trace.
  assign a_obs       = a_valid & a_ready & ~clr;
  assign d_obs       = d_valid & d_ready & ~clr;
  assign same_src    = (a_source == d_source);
  assign dup_evt     = a_obs & busy_bits[a_source] & ~(d_obs & same_src);
  assign orphan_evt  = d_obs & ~busy_bits[d_source] & ~(a_obs & same_src);
  assign unused_addr = ^a_address;

  always_comb begin
    trc_entry = '0;
    trc_entry[CA_LSB +: ADDR_W] = chip_addr;
    trc_entry[CS_LSB +: CHIP_W] = chip_sel;
    trc_entry[SR_LSB +: SRC_W]  = a_source;
    trc_entry[OP_LSB +: OPC_W]  = a_opcode;
    trc_entry[TS_LSB +: TS_W]   = ts_q;
  end

  xbar_mon_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (a_obs),
    .push_data (trc_entry),
    .pop       (trc_rd_en),
    .pop_data  (trc_rd_data),
    .full      (),
    .empty     (trc_empty),
    .count     (trc_count),
    .overflow  (trc_overflow)
  );

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic             a_hit, d_hit, busy_q, busy_d;
    logic [AGE_W-1:0] age_q, age_d;

    assign a_hit = a_obs & (a_source == SRC_W'(gi));
    assign d_hit = d_obs & (d_source == SRC_W'(gi));

    // A new request restarts the age even if the previous one retires now.
    always_comb begin
      busy_d = busy_q;
      age_d  = '0;
      if (a_hit) begin
        busy_d = 1'b1;
      end else if (d_hit) begin
        busy_d = 1'b0;
      end else if (busy_q) begin
        age_d = (age_q == AGE_W'(TIMEOUT)) ? age_q : age_q + AGE_W'(1);
      end
    end

    assign tmo_evt[gi]   = busy_q & ~a_hit & ~d_hit & (age_q == AGE_W'(TIMEOUT - 1));
    assign busy_bits[gi] = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy_q <= 1'b0;
        age_q  <= '0;
      end else begin
        busy_q <= busy_d;
        age_q  <= age_d;
      end
    end
  end

  always_comb begin
    tmo_src = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (tmo_evt[i]) tmo_src = SRC_W'(i);
    end
  end

  always_comb begin
    ts_d          = ts_q + TS_W'(1);
    a_cnt_d       = a_cnt_q + CNT_W'(a_obs);
    d_cnt_d       = d_cnt_q + CNT_W'(d_obs);
    err_dup_d     = err_dup_q | dup_evt;
    err_orphan_d  = err_orphan_q | orphan_evt;
    err_timeout_d = err_timeout_q | (|tmo_evt);
    err_src_d     = err_src_q;
    if (!(err_dup_q || err_orphan_q || err_timeout_q)) begin
      if (dup_evt)         err_src_d = a_source;
      else if (orphan_evt) err_src_d = d_source;
      else if (|tmo_evt)   err_src_d = tmo_src;
    end
    if (clr) begin
      a_cnt_d       = '0;
      d_cnt_d       = '0;
      err_dup_d     = 1'b0;
      err_orphan_d  = 1'b0;
      err_timeout_d = 1'b0;
      err_src_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q          <= '0;
      a_cnt_q       <= '0;
      d_cnt_q       <= '0;
      err_dup_q     <= 1'b0;
      err_orphan_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_src_q     <= '0;
    end else begin
      ts_q          <= ts_d;
      a_cnt_q       <= a_cnt_d;
      d_cnt_q       <= d_cnt_d;
      err_dup_q     <= err_dup_d;
      err_orphan_q  <= err_orphan_d;
      err_timeout_q <= err_timeout_d;
      err_src_q     <= err_src_d;
    end
  end

  assign a_cnt       = a_cnt_q;
  assign d_cnt       = d_cnt_q;
  assign outstanding = busy_bits;
  assign err_dup     = err_dup_q;
  assign err_orphan  = err_orphan_q;
  assign err_timeout = err_timeout_q;
  assign err_src     = err_src_q;

`ifndef SYNTHESIS
`ifdef CHECK_ENV
  always @(posedge clk) begin
    if (rst_n) begin
      if (a_obs)
        $display("%0t xbar_mon A fire addr=%h chip_sel=%0d chip_addr=%h",
                 $time, a_address, chip_sel, chip_addr);
      if (err_dup_d && !err_dup_q)
        $display("%0t xbar_mon err_dup src=%0d", $time, a_source);
      if (err_orphan_d && !err_orphan_q)
        $display("%0t xbar_mon err_orphan src=%0d", $time, d_source);
      if (err_timeout_d && !err_timeout_q)
        $display("%0t xbar_mon err_timeout src=%0d", $time, tmo_src);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_xbar_txn_monitor.sv
// Directed bench for xbar_txn_monitor: trace order/overflow, outstanding
// tracking, dup/orphan/timeout errors, clr and asynchronous reset.
module tb_xbar_txn_monitor;
  import xbar_mon_pkg::*;

  localparam int SRC_W = 4, CHIP_W = 6, ADDR_W = 64, DEPTH = 16;
  localparam int TS_W = 16, TMO = 8, CNT_W = 32;
  localparam int EW = 3 + SRC_W + CHIP_W + ADDR_W + TS_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        a_opcode;
  logic [SRC_W-1:0]  a_source, d_source;
  logic [ADDR_W-1:0] a_address, chip_addr;
  logic [CHIP_W-1:0] chip_sel;
  logic              a_valid, a_ready, d_valid, d_ready, clr, trc_rd_en;
  logic [EW-1:0]     trc_rd_data;
  logic              trc_empty, trc_overflow;
  logic [4:0]        trc_count;
  logic [CNT_W-1:0]  a_cnt, d_cnt;
  logic [15:0]       outstanding;
  logic              err_dup, err_orphan, err_timeout;
  logic [SRC_W-1:0]  err_src;

  logic [TS_W-1:0]   tb_ts;
  logic [EW-1:0]     ent [0:31];
  logic [EW-1:0]     tmp;
  trc_entry_t        head;
  int n_checks = 0;
  int n_pass   = 0;

  xbar_txn_monitor #(
    .SRC_W(SRC_W), .CHIP_W(CHIP_W), .ADDR_W(ADDR_W), .TRACE_DEPTH(DEPTH),
    .TS_W(TS_W), .TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a_opcode(a_opcode), .a_source(a_source),
    .a_address(a_address), .a_valid(a_valid), .a_ready(a_ready),
    .chip_sel(chip_sel), .chip_addr(chip_addr), .d_source(d_source),
    .d_valid(d_valid), .d_ready(d_ready), .clr(clr), .trc_rd_en(trc_rd_en),
    .trc_rd_data(trc_rd_data), .trc_empty(trc_empty), .trc_count(trc_count),
    .trc_overflow(trc_overflow), .a_cnt(a_cnt), .d_cnt(d_cnt),
    .outstanding(outstanding), .err_dup(err_dup), .err_orphan(err_orphan),
    .err_timeout(err_timeout), .err_src(err_src)
  );

  always #5 clk = ~clk;

  // Reference timestamp: free-running from reset release, one per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 16'd1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; a_ready = 0; d_valid = 0; d_ready = 0; clr = 0; trc_rd_en = 0;
    a_opcode = 0; a_source = 0; a_address = 0; chip_sel = 0; chip_addr = 0;
    d_source = 0;
  endtask

  // One bus cycle; returns the trace entry an A fire in this cycle should produce.
  task automatic cyc(input bit av, input int as, input int cs, input logic [63:0] ca,
                     input bit dv, input int ds, input bit rd, output logic [EW-1:0] e);
    a_valid = av; a_ready = av; a_source = 4'(as); a_opcode = 3'(as);
    chip_sel = 6'(cs); chip_addr = ca; a_address = ca ^ 64'hF000_0000_0000_0000;
    d_valid = dv; d_ready = dv; d_source = 4'(ds); trc_rd_en = rd;
    e = {tb_ts, 3'(as), 4'(as), 6'(cs), ca};
    step();
    idle();
  endtask

  task automatic do_clr();
    clr = 1;
    step();
    clr = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", trc_empty, 1);
    check("rst_count", trc_count, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_out", outstanding, 0);
    check("rst_errs", {err_dup, err_orphan, err_timeout, trc_overflow}, 0);
    rst_n = 1;

    // Pop on empty is ignored.
    cyc(0, 0, 0, 0, 0, 0, 1, tmp);
    check("rd_empty_count", trc_count, 0);
    check("rd_empty_flag", trc_empty, 1);

    // Three traced fires, then retire them, then drain in order.
    for (int i = 0; i < 3; i++) cyc(1, i + 1, 5, 64'h100 + 64'(8 * i), 0, 0, 0, ent[i]);
    check("t1_count", trc_count, 3);
    check("t1_a_cnt", a_cnt, 3);
    check("t1_out", outstanding, 16'h000E);
    for (int s = 1; s <= 3; s++) cyc(0, 0, 0, 0, 1, s, 0, tmp);
    check("t1_out_clr", outstanding, 0);
    check("t1_d_cnt", d_cnt, 3);
    check("t1_noerr", {err_dup, err_orphan, err_timeout}, 0);
    for (int i = 0; i < 3; i++) begin
      head = trc_entry_t'(trc_rd_data);
      check($sformatf("t1_pop%0d", i), trc_rd_data, ent[i]);
      check($sformatf("t1_ts%0d", i), head.ts, 16'(ent[0][EW-1 -: TS_W] + 16'(i)));
      cyc(0, 0, 0, 0, 0, 0, 1, tmp);
    end
    check("t1_drained", trc_empty, 1);

    // 17 fires into a 16-deep trace; each cycle retires the previous source.
    do_clr();
    for (int i = 0; i < 17; i++)
      cyc(1, i % 16, i, 64'h1000 + 64'(i), i > 0, (i + 15) % 16, 0, ent[i]);
    check("ovf_count", trc_count, 16);
    check("ovf_flag", trc_overflow, 1);
    check("ovf_head", trc_rd_data, ent[0]);
    check("ovf_a_cnt", a_cnt, 17);
    cyc(1, 1, 63, 64'hABCD, 1, 0, 1, ent[17]);
    check("pp_full_count", trc_count, 16);
    check("pp_full_head", trc_rd_data, ent[1]);
    cyc(0, 0, 0, 0, 1, 1, 0, tmp);
    check("ovf_out", outstanding, 0);
    check("ovf_d_cnt", d_cnt, 18);
    check("ovf_noerr", {err_dup, err_orphan, err_timeout}, 0);
    for (int k = 1; k < 16; k++) begin
      check($sformatf("ovf_pop%0d", k), trc_rd_data, ent[k]);
      cyc(0, 0, 0, 0, 0, 0, 1, tmp);
    end
    check("ovf_pop_pp", trc_rd_data, ent[17]);
    cyc(0, 0, 0, 0, 0, 0, 1, tmp);
    check("ovf_drained", trc_empty, 1);

    // Full FIFO with push and pop together must not overflow.
    do_clr();
    check("clr_ovf", trc_overflow, 0);
    for (int i = 0; i < 16; i++)
      cyc(1, i, 1, 64'(i), i > 0, (i + 15) % 16, 0, tmp);
    cyc(1, 0, 2, 64'h55, 1, 15, 1, tmp);
    check("pp_count", trc_count, 16);
    check("pp_no_ovf", trc_overflow, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, tmp);

    // Orphan response.
    do_clr();
    cyc(1, 4, 1, 64'h40, 0, 0, 0, tmp);
    check("orph_out_set", outstanding, 16'h0010);
    cyc(0, 0, 0, 0, 1, 4, 0, tmp);
    check("orph_out_clr", outstanding, 0);
    check("orph_none", err_orphan, 0);
    cyc(0, 0, 0, 0, 1, 4, 0, tmp);
    check("orph_flag", err_orphan, 1);
    check("orph_src", err_src, 4);
    check("orph_nodup", err_dup, 0);

    // Duplicate request; same-cycle A+D on a busy source is legal.
    do_clr();
    check("clr_errs", {err_dup, err_orphan, err_timeout, err_src}, 0);
    cyc(1, 7, 1, 64'h70, 0, 0, 0, tmp);
    cyc(1, 7, 1, 64'h78, 1, 7, 0, tmp);
    check("dup_ad_out", outstanding, 16'h0080);
    check("dup_ad_noerr", {err_dup, err_orphan}, 0);
    cyc(1, 7, 1, 64'h80, 0, 0, 0, tmp);
    check("dup_flag", err_dup, 1);
    check("dup_src", err_src, 7);
    cyc(0, 0, 0, 0, 1, 7, 0, tmp);
    check("dup_out_clr", outstanding, 0);

    // Timeout exactly TMO cycles after the request.
    do_clr();
    cyc(1, 2, 3, 64'h200, 0, 0, 0, tmp);
    repeat (TMO - 1) step();
    check("tmo_early", err_timeout, 0);
    step();
    check("tmo_flag", err_timeout, 1);
    check("tmo_src", err_src, 2);
    check("tmo_out", outstanding, 16'h0004);
    // clr alongside an A fire: fire is discarded, outstanding kept.
    cyc(1, 5, 1, 64'h500, 0, 0, 0, tmp);
    clr = 1; a_valid = 1; a_ready = 1; a_source = 4'd5;
    step();
    idle();
    check("clr_tmo", {err_dup, err_orphan, err_timeout, err_src}, 0);
    check("clr_a_cnt", a_cnt, 0);
    check("clr_empty", trc_empty, 1);
    check("clr_out_kept", outstanding, 16'h0024);
    cyc(0, 0, 0, 0, 1, 2, 0, tmp);
    cyc(0, 0, 0, 0, 1, 5, 0, tmp);
    check("tmo_retired", outstanding, 0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) cyc(1, 9 + i, 1, 64'(i), 0, 0, 0, tmp);
    check("pre_rst_count", trc_count, 5);
    check("pre_rst_out9", outstanding[9], 1);
    #2;
    rst_n = 0;
    #1;
    check("arst_count", trc_count, 0);
    check("arst_empty", trc_empty, 1);
    check("arst_out", outstanding, 0);
    check("arst_cnts", {a_cnt, d_cnt}, 0);
    check("arst_data", trc_rd_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
